// File: rtl/pe_array_pkg.sv
// Shared types and helpers for the weight-stationary PE array.
// Optional feature macro used by the array files: PE_ACC_SAT_EN.
package pe_array_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_LOAD    = 2'd1;
  localparam state_t S_COMPUTE = 2'd2;
  localparam state_t S_DRAIN   = 2'd3;

  // Narrowest accumulator that cannot overflow a full column reduction.
  function automatic int unsigned min_acc_w(input int unsigned act_w,
                                            input int unsigned wgt_w,
                                            input int unsigned rows);
    return act_w + wgt_w + $clog2(rows);
  endfunction

  // LSB of lane 'lane' in a flat bus of 'w'-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/pe_array_ws_stream_cell.sv
// One weight-stationary PE: shiftable weight, forwarded activation, gated psum.
// Build option PE_ACC_SAT_EN: saturating accumulate with a clamp indication.
module pe_ws_cell #(
  parameter int unsigned ACT_W = 8,
  parameter int unsigned WGT_W = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             w_shift,
  input  logic [WGT_W-1:0] wgt_in,
  output logic [WGT_W-1:0] wgt_out,
  input  logic [ACT_W-1:0] act_in,
  output logic [ACT_W-1:0] act_out,
  input  logic             psum_en,
  input  logic [ACC_W-1:0] psum_in,
  output logic [ACC_W-1:0] psum_out
`ifdef PE_ACC_SAT_EN
  ,
  output logic             sat_c
`endif
);

  localparam int unsigned PROD_W = ACT_W + WGT_W;

  logic [WGT_W-1:0]        wgt_q;
  logic [ACT_W-1:0]        act_q;
  logic [ACC_W-1:0]        psum_q;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]        sum;

  assign prod = PROD_W'($signed(act_in)) * PROD_W'($signed(wgt_q));

`ifdef PE_ACC_SAT_EN
  localparam int unsigned SUM_W = ACC_W + 1;
  logic signed [SUM_W-1:0] sum_ext;
  logic                    ovf;

  // One guard bit exposes overflow; clamp toward the sign of the true result.
  assign sum_ext = SUM_W'($signed(psum_in)) + SUM_W'(prod);
  assign ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
  assign sat_c   = ovf & psum_en;

  always_comb begin
    sum = sum_ext[ACC_W-1:0];
    if (ovf) begin
      sum = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = psum_in + ACC_W'(prod);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wgt_q  <= '0;
      act_q  <= '0;
      psum_q <= '0;
    end else begin
      if (w_shift) wgt_q <= wgt_in;
      act_q <= act_in;
      if (psum_en) psum_q <= sum;
    end
  end

  assign wgt_out  = wgt_q;
  assign act_out  = act_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/pe_array_ws_stream.sv
// Weight-stationary systolic MAC array with load/compute/drain control and aligned output.
// Build option PE_ACC_SAT_EN: saturating PEs plus a sticky sat_flag output.
module pe_array_ws_stream
  import pe_array_pkg::*;
#(
  parameter int unsigned ROWS  = 32,
  parameter int unsigned COLS  = 32,
  parameter int unsigned ACT_W = 8,
  parameter int unsigned WGT_W = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [COLS*WGT_W-1:0] w_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_last,
  input  logic [ROWS*ACT_W-1:0] a_data,
  output logic                  out_valid,
  output logic [COLS*ACC_W-1:0] out_sum,
  output logic                  busy,
  output logic                  done
`ifdef PE_ACC_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int unsigned L          = ROWS + COLS - 1;
  localparam int unsigned WCW        = $clog2(ROWS + 1);
  localparam int unsigned DCW        = $clog2(L + 1);
  localparam int unsigned DRAIN_LAST = (L > 1) ? L - 2 : 0;

`ifndef PE_ACC_SAT_EN
  if (ACC_W < min_acc_w(ACT_W, WGT_W, ROWS)) begin : g_acc_w_check
    $error("ACC_W too narrow for ACT_W/WGT_W/ROWS");
  end
`endif

  state_t         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           w_ready_d, a_ready_d, busy_d, done_d;
  logic           w_acc, acc;

  assign w_acc = w_valid & w_ready;
  assign acc   = a_valid & a_ready;

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (w_acc) begin
          if (wcnt_q == WCW'(ROWS - 1)) begin
            state_d = S_COMPUTE;
            wcnt_d  = '0;
          end else begin
            state_d = S_LOAD;
            wcnt_d  = wcnt_q + WCW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (acc && a_last) begin
          dcnt_d = '0;
          if (L == 1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DCW'(DRAIN_LAST)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    w_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    a_ready_d = (state_d == S_COMPUTE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
      w_ready <= 1'b0;
      a_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
      w_ready <= w_ready_d;
      a_ready <= a_ready_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // en_vec[k] is high while an accepted vector is k stages into the array.
  logic [L-1:0] vld_q, en_vec;

  if (L > 1) begin : g_en_multi
    assign en_vec = {vld_q[L-2:0], acc};
  end else begin : g_en_single
    assign en_vec = acc;
  end

  always_ff @(posedge CLK) begin
    if (RESET) vld_q <= '0;
    else       vld_q <= en_vec;
  end

  assign out_valid = vld_q[L-1];

  logic [WGT_W-1:0] wgt_bus  [ROWS+1][COLS];
  logic [ACT_W-1:0] act_bus  [ROWS][COLS+1];
  logic [ACC_W-1:0] psum_bus [ROWS+1][COLS];
`ifdef PE_ACC_SAT_EN
  logic [ROWS*COLS-1:0] sat_hits;
`endif

  // Input skew: row r sees its activation r cycles after acceptance.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [ACT_W-1:0] a_in;
    assign a_in = acc ? a_data[lane_lsb(r, ACT_W) +: ACT_W] : '0;
    if (r == 0) begin : g_pass
      assign act_bus[r][0] = a_in;
    end else begin : g_dly
      logic [ACT_W-1:0] sr [r];
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else begin
          sr[0] <= a_in;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign act_bus[r][0] = sr[r-1];
    end
    logic unused_act;
    assign unused_act = ^act_bus[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_edge
    assign wgt_bus[0][c]  = w_data[lane_lsb(c, WGT_W) +: WGT_W];
    assign psum_bus[0][c] = '0;
    logic unused_wgt;
    assign unused_wgt = ^wgt_bus[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      pe_ws_cell #(
        .ACT_W (ACT_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
      ) u_cell (
        .CLK      (CLK),
        .RESET    (RESET),
        .w_shift  (w_acc),
        .wgt_in   (wgt_bus[r][c]),
        .wgt_out  (wgt_bus[r+1][c]),
        .act_in   (act_bus[r][c]),
        .act_out  (act_bus[r][c+1]),
        .psum_en  (en_vec[r+c]),
        .psum_in  (psum_bus[r][c]),
        .psum_out (psum_bus[r+1][c])
`ifdef PE_ACC_SAT_EN
        ,
        .sat_c    (sat_hits[r*COLS+c])
`endif
      );
    end
  end

  // Output de-skew: column c waits COLS-1-c stages; stages only move on valid data so out_sum holds.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int unsigned D = COLS - 1 - c;
    logic [ACC_W-1:0] col_out;
    if (D == 0) begin : g_direct
      assign col_out = psum_bus[ROWS][c];
    end else begin : g_dly
      logic [ACC_W-1:0] dq [D];
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int i = 0; i < D; i++) dq[i] <= '0;
        end else begin
          if (en_vec[ROWS+c]) dq[0] <= psum_bus[ROWS][c];
          for (int i = 1; i < D; i++) begin
            if (en_vec[ROWS+c+i]) dq[i] <= dq[i-1];
          end
        end
      end
      assign col_out = dq[D-1];
    end
    assign out_sum[lane_lsb(c, ACC_W) +: ACC_W] = col_out;
  end

`ifdef PE_ACC_SAT_EN
  // Sticky clamp flag, cleared when a new weight load starts.
  always_ff @(posedge CLK) begin
    if (RESET)                            sat_flag <= 1'b0;
    else if (state_q == S_IDLE && w_acc)  sat_flag <= 1'b0;
    else if (|sat_hits)                   sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pe_array_ws_stream.sv
// Directed bench: 2x2 (function, bubbles, handshake gating, reset), 4x4 (extremes), 1x3 (ROWS=1).
module tb_pe_array_ws_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pulse = 0;
  int   n_done = 0;
  int   exp_done = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int L_A = 3;
  localparam int L_B = 7;
  localparam int L_C = 3;

  // 2x2 instance
  logic        w_valid_a = 0, a_valid_a = 0, a_last_a = 0;
  logic [15:0] w_data_a = '0, a_data_a = '0;
  logic        w_ready_a, a_ready_a, out_valid_a, busy_a, done_a;
  logic [63:0] out_sum_a;
  // 4x4 instance
  logic        w_valid_b = 0, a_valid_b = 0, a_last_b = 0;
  logic [31:0] w_data_b = '0, a_data_b = '0;
  logic        w_ready_b, a_ready_b, out_valid_b, busy_b, done_b;
  logic [127:0] out_sum_b;
  // 1x3 instance
  logic        w_valid_c = 0, a_valid_c = 0, a_last_c = 0;
  logic [23:0] w_data_c = '0;
  logic [7:0]  a_data_c = '0;
  logic        w_ready_c, a_ready_c, out_valid_c, busy_c, done_c;
  logic [95:0] out_sum_c;
`ifdef PE_ACC_SAT_EN
  logic sat_a, sat_b, sat_c;
`endif

  pe_array_ws_stream #(.ROWS(2), .COLS(2), .ACT_W(8), .WGT_W(8), .ACC_W(32)) u_dut_a (
    .CLK(clk), .RESET(rst), .w_valid(w_valid_a), .w_ready(w_ready_a), .w_data(w_data_a),
    .a_valid(a_valid_a), .a_ready(a_ready_a), .a_last(a_last_a), .a_data(a_data_a),
    .out_valid(out_valid_a), .out_sum(out_sum_a), .busy(busy_a), .done(done_a)
`ifdef PE_ACC_SAT_EN
    , .sat_flag(sat_a)
`endif
  );

  pe_array_ws_stream #(.ROWS(4), .COLS(4), .ACT_W(8), .WGT_W(8), .ACC_W(32)) u_dut_b (
    .CLK(clk), .RESET(rst), .w_valid(w_valid_b), .w_ready(w_ready_b), .w_data(w_data_b),
    .a_valid(a_valid_b), .a_ready(a_ready_b), .a_last(a_last_b), .a_data(a_data_b),
    .out_valid(out_valid_b), .out_sum(out_sum_b), .busy(busy_b), .done(done_b)
`ifdef PE_ACC_SAT_EN
    , .sat_flag(sat_b)
`endif
  );

  pe_array_ws_stream #(.ROWS(1), .COLS(3), .ACT_W(8), .WGT_W(8), .ACC_W(32)) u_dut_c (
    .CLK(clk), .RESET(rst), .w_valid(w_valid_c), .w_ready(w_ready_c), .w_data(w_data_c),
    .a_valid(a_valid_c), .a_ready(a_ready_c), .a_last(a_last_c), .a_data(a_data_c),
    .out_valid(out_valid_c), .out_sum(out_sum_c), .busy(busy_c), .done(done_c)
`ifdef PE_ACC_SAT_EN
    , .sat_flag(sat_c)
`endif
  );

  logic [63:0] sb_sum [$];
  int          sb_cyc [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack2(input int c0, input int c1);
    return {32'(c1), 32'(c0)};
  endfunction

  function automatic logic [15:0] act2(input int r0, input int r1);
    return {8'(r1), 8'(r0)};
  endfunction

  task automatic w_beat_a(input logic [15:0] d);
    int k = 0;
    w_valid_a = 1'b1;
    w_data_a  = d;
    while (!w_ready_a && k < 10) begin tick(); k++; end
    check("w_ready_wait_a", w_ready_a, 1);
    tick();
    w_valid_a = 1'b0;
  endtask

  task automatic send_a(input logic [15:0] d, input logic last, input logic [63:0] exp);
    int k = 0;
    a_valid_a = 1'b1;
    a_data_a  = d;
    a_last_a  = last;
    while (!a_ready_a && k < 10) begin tick(); k++; end
    check("a_ready_wait_a", a_ready_a, 1);
    sb_sum.push_back(exp);
    sb_cyc.push_back(cyc + L_A);
    if (last) exp_done = cyc + L_A;
    tick();
    a_valid_a = 1'b0;
    a_last_a  = 1'b0;
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while (busy_a && k < 40) begin tick(); k++; end
    check("drain_to_idle_a", busy_a, 0);
  endtask

  // Scoreboard for the 2x2 instance: every pulse must match a queued vector at its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a) begin
        n_pulse++;
        if (sb_sum.size() == 0) begin
          check("extra_out_valid_a", out_valid_a, 0);
        end else begin
          check("sum_a", out_sum_a, sb_sum.pop_front());
          check("latency_a", 64'(cyc), 64'(sb_cyc.pop_front()));
        end
      end
      if (done_a) begin
        n_done++;
        check("done_cycle_a", 64'(cyc), 64'(exp_done));
        exp_done = -1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int p0;
    int d0;

    repeat (2) tick();
    check("rst_w_ready", w_ready_a, 0);
    check("rst_a_ready", a_ready_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_sum", out_sum_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_w_ready_b", w_ready_b, 0);
    rst = 1'b0;
    tick();
    check("idle_w_ready", w_ready_a, 1);
    check("idle_a_ready", a_ready_a, 0);
    check("idle_busy", busy_a, 0);

    // 4x4 extremes: 4 * 127 * -128 per column.
    w_valid_b = 1'b1;
    w_data_b  = {4{8'd127}};
    repeat (5) tick();
    w_valid_b = 1'b0;
    check("b_compute_a_ready", a_ready_b, 1);
    a_valid_b = 1'b1; a_last_b = 1'b1; a_data_b = {4{8'h80}};
    tick();
    a_valid_b = 1'b0; a_last_b = 1'b0;
    k = 1;
    while (!out_valid_b && k < 20) begin tick(); k++; end
    check("b_latency", 64'(k), 64'(L_B));
    for (int c = 0; c < 4; c++) check("b_col_sum", 64'(out_sum_b[c*32 +: 32]), 64'(32'hFFFF0200));
    check("b_done", done_b, 1);
    tick();
    check("b_done_pulse", done_b, 0);
    check("b_idle", busy_b, 0);

    // ROWS=1: one weight beat goes straight to COMPUTE.
    w_valid_c = 1'b1;
    w_data_c  = {8'd3, 8'hFE, 8'd5};
    tick();
    w_valid_c = 1'b0;
    check("c_single_beat_compute", a_ready_c, 1);
    check("c_w_ready_off", w_ready_c, 0);
    a_valid_c = 1'b1; a_last_c = 1'b1; a_data_c = 8'd7;
    tick();
    a_valid_c = 1'b0; a_last_c = 1'b0;
    k = 1;
    while (!out_valid_c && k < 20) begin tick(); k++; end
    check("c_latency", 64'(k), 64'(L_C));
    check("c_col0", 64'(out_sum_c[31:0]), 64'(32'd35));
    check("c_col1", 64'(out_sum_c[63:32]), 64'(32'hFFFFFFF2));
    check("c_col2", 64'(out_sum_c[95:64]), 64'(32'd21));
    check("c_done", done_c, 1);

    // Basic 2x2 tile with a_valid held during LOAD.
    a_valid_a = 1'b1;
    a_data_a  = act2(99, 99);
    w_beat_a({8'd4, 8'd3});
    check("load_a_ready_off", a_ready_a, 0);
    check("load_w_ready_on", w_ready_a, 1);
    check("load_busy", busy_a, 1);
    w_beat_a({8'd2, 8'd1});
    check("compute_w_ready_off", w_ready_a, 0);
    send_a(act2(5, 6), 1'b1, pack2(23, 34));
    d0 = n_done;
    wait_idle_a();
    repeat (3) tick();
    check("hold_out_valid", out_valid_a, 0);
    check("hold_out_sum", out_sum_a, pack2(23, 34));
    check("basic_done_count", 64'(n_done - d0), 64'(1));

    // Back-to-back with a bubble; w_valid held high through COMPUTE/DRAIN.
    w_beat_a({8'd4, 8'd3});
    w_beat_a({8'd2, 8'd1});
    p0 = n_pulse;
    w_valid_a = 1'b1;
    w_data_a  = 16'h7f7f;
    send_a(act2(1, 2), 1'b0, pack2(7, 10));
    send_a(act2(-1, 3), 1'b0, pack2(8, 10));
    check("compute_w_ready_held", w_ready_a, 0);
    tick();
    send_a(act2(10, -5), 1'b0, pack2(-5, 0));
    send_a(act2(-128, 127), 1'b1, pack2(253, 252));
    check("drain_w_ready", w_ready_a, 0);
    check("drain_a_ready", a_ready_a, 0);
    w_valid_a = 1'b0;
    wait_idle_a();
    tick();
    check("b2b_pulse_count", 64'(n_pulse - p0), 64'(4));
    check("b2b_scoreboard_empty", 64'(sb_sum.size()), 64'(0));

    // Reset with two vectors in flight.
    w_beat_a({8'd4, 8'd3});
    w_beat_a({8'd2, 8'd1});
    send_a(act2(1, 1), 1'b0, pack2(4, 6));
    send_a(act2(2, 2), 1'b0, pack2(8, 12));
    rst = 1'b1;
    sb_sum.delete();
    sb_cyc.delete();
    exp_done = -1;
    tick();
    check("mid_rst_w_ready", w_ready_a, 0);
    check("mid_rst_a_ready", a_ready_a, 0);
    check("mid_rst_out_valid", out_valid_a, 0);
    check("mid_rst_out_sum", out_sum_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    rst = 1'b0;
    p0 = n_pulse;
    d0 = n_done;
    repeat (8) tick();
    check("post_rst_no_pulse", 64'(n_pulse - p0), 64'(0));
    check("post_rst_no_done", 64'(n_done - d0), 64'(0));
    w_beat_a({8'd4, 8'd3});
    w_beat_a({8'd2, 8'd1});
    send_a(act2(5, 6), 1'b1, pack2(23, 34));
    wait_idle_a();
    tick();
    check("fresh_pulse_count", 64'(n_pulse - p0), 64'(1));
    check("fresh_done_count", 64'(n_done - d0), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_array_ws_stream.md
Name: pe_array_ws_stream

Overview:
- Parametrised weight-stationary systolic MAC array; successor to the fixed 8-bit/32-bit PE array.
- Adds configurable operand/accumulator widths, controlled weight preload, internal input skew, output de-skew, valid/ready input handshake and a load/compute/drain state machine.
- Sits between the activation/weight feeders and the output writeback.
- Output is one aligned COLS-wide result vector per accepted activation vector.

Parameters:
- ROWS, 32, array rows (reduction depth); ≥1
- COLS, 32, array columns (output channels); ≥1
- ACT_W, 8, signed activation width
- WGT_W, 8, signed weight width
- ACC_W, 32, signed accumulator/result width; must be ≥ ACT_W+WGT_W+clog2(ROWS)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accepted when w_valid&w_ready
- w_data  in  COLS*WGT_W  one weight row; column c at [c*WGT_W +: WGT_W]
- a_valid  in  1  activation vector valid
- a_ready  out  1  activation accepted when a_valid&a_ready
- a_last  in  1  marks final activation vector of a tile
- a_data  in  ROWS*ACT_W  one activation vector; row r at [r*ACT_W +: ACT_W]
- out_valid  out  1  aligned result vector valid (no backpressure)
- out_sum  out  COLS*ACC_W  column c at [c*ACC_W +: ACC_W]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when DRAIN completes

Behaviour:
- One clock. Reset is synchronous and active-high, with ports named CLK and RESET as elsewhere in the codebase.
- Reset clears state to IDLE, weight counter, all weights, skew/de-skew/psum registers and valid pipeline.
- Outputs after reset: w_ready=0, a_ready=0, out_valid=0, out_sum=0, busy=0, done=0.
- Reset mid-operation aborts the tile. No out_valid or done may follow from pre-reset data.
- FSM states and transitions:
  - IDLE: w_ready=1. The first w beat loads and moves to LOAD.
  - LOAD: w_ready=1. Weights shift downward one row per accepted beat; after ROWS accepted beats, the first beat sits in row ROWS-1 and the last beat in row 0. Weight counter counts 0..ROWS-1; on the ROWS-th beat, move to COMPUTE. ROWS=1 goes straight from IDLE to COMPUTE on a single beat.
  - COMPUTE: a_ready=1, w_ready=0, weights frozen. An accepted vector with a_last=1 moves to DRAIN.
  - DRAIN: a_ready=0, w_ready=0. A counter runs L=ROWS+COLS-1 cycles after the last acceptance. done pulses in the cycle the last out_valid is asserted, then IDLE.
- Bubbles: a_valid=0 in COMPUTE injects zero activations with valid=0. The valid pipeline tracks each accepted vector individually.
- Dataflow:
  - Row r input is delayed r cycles (skew chain).
  - Each PE registers its activation (passed right) and psum (passed down): psum_out = psum_in + act*wgt, signed, sign-extended to ACC_W, two's-complement wrap by default.
  - Row 0 psum_in = 0.
  - Column c output is delayed COLS-1-c cycles (de-skew).
- Latency: a vector accepted in cycle t gives out_valid=1 with its full out_sum in cycle t+L. Throughput is 1 vector/cycle.
- out_sum is held at its last value when out_valid=0. It is compared only when out_valid=1.
- Simultaneous events: in COMPUTE, w_valid is ignored. a_valid in IDLE/LOAD/DRAIN is not accepted.

Optional Feature:
- Macro PE_ACC_SAT_EN.
- Defined: each PE add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and a sticky output sat_flag (1 bit) sets on any clamp and clears on reset or on entering LOAD.
- Undefined: wrap arithmetic and no sat_flag port.

Decomposition:
- Package pe_array_pkg:
  - FSM state enum (S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN)
  - width-check constants/functions (clog2, min ACC_W)
  - lane-slice helper function
- Sub-module pe_ws_cell, one PE, parameters ACT_W/WGT_W/ACC_W:
  - weight register with shift-enable
  - activation register
  - MAC/psum register
  - PE_ACC_SAT_EN logic
- Top module holds the FSM, counters, skew/de-skew chains and valid pipeline.

Test Plan:
- ROWS=COLS=2, ACC_W=32: load w rows {c1=4,c0=3} then {c1=2,c0=1}, stream a=(r1=6,r0=5) with a_last → after L=3 cycles out_sum: c0=5*1+6*3=23, c1=5*2+6*4=34; done in same cycle.
- Back-to-back 4 vectors with one a_valid bubble → exactly 4 out_valid pulses, each L cycles after its acceptance, with correct sums, no extra pulse.
- ROWS=COLS=4, all weights 127, all activations -128 → every column -65024. Under PE_ACC_SAT_EN with ACC_W=16 (constraint waived), the result clamps to -32768 and sat_flag=1.
- RESET asserted mid-COMPUTE with 2 vectors in flight → next cycle all outputs 0, state IDLE, no out_valid/done afterwards; a fresh load works.
- w_valid held high during COMPUTE/DRAIN, a_valid high in LOAD → w_ready/a_ready stay 0, weights and results unchanged.
- ROWS=1, COLS=3: a single weight beat enters COMPUTE; latency L=3 is verified.
